// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM states and flag bit positions for exec_unit
package exec_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;
  typedef enum logic {S_IDLE, S_ITER} state_t;
  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: shift-add multiplier / restoring unsigned divider, one step per clock for WIDTH clocks
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_step
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d, mode_q, mode_d;
  logic [WIDTH:0] tmp;
  logic [WIDTH+1:0] trial;
  assign last_step = run_q && cnt_q == CW'(WIDTH - 1);
  // Results are the post-step values so the caller can capture them on the final edge.
  assign product   = acc_d;
  assign remainder = acc_d;
  assign quotient  = y_d;
  always_comb begin
    tmp = {acc_q, y_q[WIDTH-1]};
    trial = {1'b0, tmp} - {2'b0, x_q};
    acc_d = acc_q;
    x_d = x_q;
    y_d = y_q;
    cnt_d = cnt_q;
    run_d = run_q;
    mode_d = mode_q;
    if (load) begin
      acc_d = '0;
      x_d = mode ? b : a;
      y_d = mode ? a : b;
      cnt_d = '0;
      run_d = 1'b1;
      mode_d = mode;
    end else if (run_q) begin
      if (mode_q) begin
        acc_d = trial[WIDTH+1] ? tmp[WIDTH-1:0] : trial[WIDTH-1:0];
        y_d = {y_q[WIDTH-2:0], ~trial[WIDTH+1]};
      end else begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end
      cnt_d = cnt_q + 1'b1;
      run_d = ~last_step;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      x_q <= '0;
      y_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      x_q <= x_d;
      y_q <= y_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      mode_q <= mode_d;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-cycle ALU plus iterative MUL/DIVU/REMU behind a start/busy/done handshake
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             dz,
  output logic             illegal,
  output logic             busy,
  output logic             done
);
  localparam int SW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [3:0] op_q, op_d, flags_q, flags_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, sra_res, it_res, wr_res;
  logic bz_q, bz_d, dz_q, dz_d, ill_q, ill_d, done_q, done_d;
  logic alu_c, alu_v, wr_c, wr_v, load, is_iter, write;
  logic [WIDTH:0] sum, diff;
  logic [SW-1:0] sh;
  logic [WIDTH-1:0] product, quotient, remainder;
  logic last_step;
  iter_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk(clk), .rst(rst), .load(load), .mode(op != OP_MUL), .a(opA), .b(opB),
    .product(product), .quotient(quotient), .remainder(remainder), .last_step(last_step)
  );
  assign sh = opB[SW-1:0];
  assign sum = {1'b0, opA} + {1'b0, opB};
  assign diff = {1'b0, opA} - {1'b0, opB};
  assign sra_res = $signed(opA) >>> sh;
  assign is_iter = op == OP_MUL || op == OP_DIVU || op == OP_REMU;
  assign it_res = op_q == OP_MUL ? product : op_q == OP_DIVU ? quotient : remainder;
  always_comb begin
    alu_res = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = opA[WIDTH-1] == opB[WIDTH-1] && sum[WIDTH-1] != opA[WIDTH-1];
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c = ~diff[WIDTH];
        alu_v = opA[WIDTH-1] != opB[WIDTH-1] && diff[WIDTH-1] != opA[WIDTH-1];
      end
      OP_AND: alu_res = opA & opB;
      OP_OR:  alu_res = opA | opB;
      OP_XOR: alu_res = opA ^ opB;
      OP_SLL: alu_res = opA << sh;
      OP_SRL: alu_res = opA >> sh;
      OP_SRA: alu_res = sra_res;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    bz_d = bz_q;
    dz_d = dz_q;
    ill_d = ill_q;
    load = 1'b0;
    write = 1'b0;
    wr_res = alu_res;
    wr_c = alu_c;
    wr_v = alu_v;
    if (state_q == S_IDLE && start) begin
      if (is_iter) begin
        load = 1'b1;
        state_d = S_ITER;
        op_d = op;
        bz_d = opB == '0;
      end else begin
        write = 1'b1;
        dz_d = 1'b0;
        ill_d = op > OP_REMU;
      end
    end else if (state_q == S_ITER && last_step) begin
      write = 1'b1;
      wr_res = it_res;
      wr_c = 1'b0;
      wr_v = 1'b0;
      dz_d = bz_q && op_q != OP_MUL;
      ill_d = 1'b0;
      state_d = S_IDLE;
    end
    done_d = write;
    result_d = write ? wr_res : result_q;
    flags_d = flags_q;
    if (write) begin
      flags_d[F_Z] = wr_res == '0;
      flags_d[F_N] = wr_res[WIDTH-1];
      flags_d[F_C] = wr_c;
      flags_d[F_V] = wr_v;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q <= OP_ADD;
      bz_q <= 1'b0;
      result_q <= '0;
      flags_q <= '0;
      dz_q <= 1'b0;
      ill_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      bz_q <= bz_d;
      result_q <= result_d;
      flags_q <= flags_d;
      dz_q <= dz_d;
      ill_q <= ill_d;
      done_q <= done_d;
    end
  end
  assign result = result_q;
  assign flags = flags_q;
  assign dz = dz_q;
  assign illegal = ill_q;
  assign busy = state_q == S_ITER;
  assign done = done_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: table-driven vectors and handshake corner cases checked through a scoreboard
module tb_exec_unit;
  import exec_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] op = 4'd0;
  logic [W-1:0] opA = '0, opB = '0;
  logic [W-1:0] result;
  logic [3:0] flags;
  logic dz, illegal, busy, done;
  exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .result(result), .flags(flags), .dz(dz), .illegal(illegal), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a, b, res;
    logic [3:0] fl;
    logic dz, ill;
  } vec_t;
  typedef struct {
    logic [W-1:0] res;
    logic [3:0] fl;
    logic dz, ill;
  } exp_t;
  exp_t sb[$];
  vec_t tv[$];
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 want no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags", W'(flags), W'(e.fl));
        chk("dz", W'(dz), W'(e.dz));
        chk("illegal", W'(illegal), W'(e.ill));
      end
    end
  end
  task automatic push_exp(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.fl = v.fl;
    e.dz = v.dz;
    e.ill = v.ill;
    sb.push_back(e);
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic issue(input vec_t v);
    push_exp(v);
    @(negedge clk);
    start = 1'b1;
    op = v.op;
    opA = v.a;
    opB = v.b;
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask
  function automatic vec_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    v.op = o;
    v.a = a;
    v.b = b;
    v.res = o == OP_MUL ? a * b : o == OP_DIVU ? a / b : a % b;
    v.fl = {v.res == '0, v.res[W-1], 2'b00};
    v.dz = 1'b0;
    v.ill = 1'b0;
    return v;
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    int nb, seen, nd;
    tv.push_back('{OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0101, 1'b0, 1'b0});
    tv.push_back('{OP_SUB, 32'h5, 32'h5, 32'h0, 4'b1010, 1'b0, 1'b0});
    tv.push_back('{OP_SUB, 32'h3, 32'h5, 32'hFFFFFFFE, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1010, 1'b0, 1'b0});
    tv.push_back('{OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011, 1'b0, 1'b0});
    tv.push_back('{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{OP_OR, 32'h0F, 32'hF0, 32'hFF, 4'b0000, 1'b0, 1'b0});
    tv.push_back('{OP_XOR, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 4'b0000, 1'b0, 1'b0});
    tv.push_back('{OP_SLL, 32'h1, 32'd31, 32'h80000000, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{OP_SLL, 32'h1, 32'h23, 32'h8, 4'b0000, 1'b0, 1'b0});
    tv.push_back('{OP_SRL, 32'h80000000, 32'h4, 32'h08000000, 4'b0000, 1'b0, 1'b0});
    tv.push_back('{OP_SRA, 32'h80000000, 32'h4, 32'hF8000000, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{OP_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0000, 1'b0, 1'b0});
    tv.push_back('{OP_SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 4'b1000, 1'b0, 1'b0});
    tv.push_back('{OP_MUL, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD, 4'b0100, 1'b0, 1'b0});
    tv.push_back('{OP_DIVU, 32'd42, 32'h0, 32'hFFFFFFFF, 4'b0100, 1'b1, 1'b0});
    tv.push_back('{OP_REMU, 32'd42, 32'h0, 32'd42, 4'b0000, 1'b1, 1'b0});
    tv.push_back('{OP_AND, 32'hFF, 32'h0F, 32'h0F, 4'b0000, 1'b0, 1'b0});
    tv.push_back('{4'd13, 32'h1234, 32'h5678, 32'h0, 4'b1000, 1'b0, 1'b1});
    tv.push_back('{OP_OR, 32'h0, 32'h1, 32'h1, 4'b0000, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_result", result, '0);
    chk("reset_flags", W'(flags), '0);
    chk("reset_dz_ill", W'({dz, illegal}), '0);
    chk("reset_busy_done", W'({busy, done}), '0);
    push_exp(tv[0]);
    start = 1'b1;
    op = tv[0].op;
    opA = tv[0].a;
    opB = tv[0].b;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("add_done_pulse", W'(done), W'(1'b1));
    @(negedge clk);
    #1;
    chk("add_done_width", W'(done), W'(1'b0));
    drain();
    for (int i = 1; i < tv.size(); i++) issue(tv[i]);
    v = '{OP_MUL, 32'h00010001, 32'h0000FFFF, 32'hFFFFFFFF, 4'b0100, 1'b0, 1'b0};
    push_exp(v);
    @(negedge clk);
    start = 1'b1;
    op = v.op;
    opA = v.a;
    opB = v.b;
    @(negedge clk);
    nb = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nb++;
      start = i == 5;
      op = OP_ADD;
      opA = 32'h1;
      opB = 32'h2;
      @(negedge clk);
    end
    start = 1'b0;
    chk("mul_busy_cycles", W'(nb), W'(32));
    chk("mul_done_seen", W'(seen), W'(1));
    chk("mul_busy_at_done", W'(busy), W'(1'b0));
    drain();
    push_exp('{OP_DIVU, 32'd100, 32'd7, 32'd14, 4'b0000, 1'b0, 1'b0});
    push_exp('{OP_REMU, 32'd100, 32'd7, 32'd2, 4'b0000, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b1;
    op = OP_DIVU;
    opA = 32'd100;
    opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    opA = '0;
    opB = '0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("divu_done", W'(done), W'(1'b1));
    start = 1'b1;
    op = OP_REMU;
    opA = 32'd100;
    opB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("b2b_busy", W'(busy), W'(1'b1));
    chk("b2b_done_low", W'(done), W'(1'b0));
    drain();
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      logic [3:0] o;
      a = $urandom;
      b = (i < 3) ? $urandom : W'($urandom_range(1, 1000));
      if (b == '0) b = 32'd1;
      o = 4'(OP_MUL + 4'($urandom_range(0, 2)));
      issue(model(o, a, b));
    end
    @(negedge clk);
    start = 1'b1;
    op = OP_MUL;
    opA = 32'd3;
    opB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", W'(nd), '0);
    chk("abort_busy", W'(busy), '0);
    chk("abort_result", result, '0);
    chk("abort_flags", W'(flags), '0);
    issue('{4'd13, 32'hDEAD, 32'hBEEF, 32'h0, 4'b1000, 1'b0, 1'b1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
